johnson_seq_gen: RTL and testbench
==================================

// Module: johnson_seq_gen
// PURPOSE
//  Parametrised Johnson (twisted-ring) counter producing 2*WIDTH glitch-free states.
//  Adds enable, up/down direction, synchronous load by index, binary index, one-hot decode and terminal-count pulse.
//  Sits in the counters library as the general sequencer for phase generators and timing strobes.
// PARAMETERS
//  WIDTH   4   ring width in bits; >=2; sequence length 2*WIDTH
//  IDX_W   $clog2(2*WIDTH)  width of binary index (derived localparam, not overridable)
// PORTS
//  clk       in   1          rising-edge clock
//  res       in   1          synchronous active-high reset
//  en        in   1          advance one state this cycle
//  up        in   1          1 = forward sequence, 0 = reverse
//  load      in   1          load state from load_idx
//  load_idx  in   IDX_W      target state index 0..2*WIDTH-1
//  q         out  WIDTH      Johnson code (registered)
//  idx       out  IDX_W      binary index of q (combinational from q)
//  dec       out  2*WIDTH    one-hot decode of q; dec[idx]=1
//  tc        out  1          terminal-count pulse (combinational)
//  err       out  1          illegal-code flag (see CONFIGURATION)
// BEHAVIOUR
//  - Clock and reset: single clock domain; one clock edge per state change.
//  - Reset: res=1 at posedge -> q=0 next cycle; idx=0, dec=1, tc=0, err=0.
//  - Priority: res > load > en. en=0 with no load holds q.
//  - Forward (en=1, up=1): q <= {q[WIDTH-2:0], ~q[WIDTH-1]}.
//  - Reverse (en=1, up=0): q <= {~q[0], q[WIDTH-1:1]}.
//  - WIDTH=4 forward: 0000,0001,0011,0111,1111,1110,1100,1000, then wrap to 0000. Reverse is the exact inverse.
//  - Index mapping:
//    - q = k low ones -> idx = k (0..WIDTH).
//    - q = k low zeros (rest ones, k>=1) -> idx = WIDTH+k.
//  - load=1: q <= Johnson code of load_idx in one cycle, regardless of en and up.
//  - load_idx >= 2*WIDTH: load is ignored and q holds.
//  - tc = en & ~load & ~res & ((up & idx==2*WIDTH-1) | (~up & idx==0)).
//    - Asserted during the cycle whose edge performs the wrap.
//  - Legal code: q is a single contiguous run of ones anchored at bit 0 or at bit WIDTH-1 (all-0/all-1 legal).
//  - Illegal codes are unreachable through reset, load or stepping.
//  - An illegal code drives dec = 0 and idx = 0.
//  - Direction may change on any cycle; the next step uses the new up value. No bubble.
// CONFIGURATION
//  JOHNSON_SELF_CORRECT_EN defined:
//   - err = ~legal(q), combinational.
//   - Any illegal q is forced to 0 at the next posedge, overriding en. load and res still take priority.
//  Not defined:
//   - err tied 0.
//   - Illegal codes shift by the normal rules and are never corrected.
// STRUCTURE
//  johnson_pkg:
//   - function jc_encode(idx, width)
//   - function jc_decode(q) -> idx
//   - function jc_legal(q)
//   - localparam helpers for IDX_W
//  Sub-module johnson_decode (combinational: q -> idx, dec, legal), instantiated once.
//  The top holds the next-state register and tc logic.
// TESTING  (WIDTH=4)
//  - res=1 mid-count at q=0111 -> q=0000, idx=0, dec=8'h01 next cycle, even with en=1 and load=1.
//  - en=1, up=1 for 9 cycles from 0000:
//    - q walks 0001..1000 then 0000.
//    - tc=1 only in the cycle with q=1000; idx 0..7 then 0.
//  - en=1, up=0 from 0000:
//    - Next q=1000, then 1100.
//    - tc=1 in the first cycle (idx=0).
//    - Toggling up at q=1100 returns q to 1000 next.
//  - load=1, load_idx=5, en=1, up=1 -> q=1110, dec=8'h20.
//  - load_idx=9 -> q holds.
//  - en=0 for 3 cycles at q=0011 -> q stays 0011, tc=0.
//  - Self-correct (macro defined): force q=0101 -> err=1, dec=0, q=0000 next cycle with en=0.
//  - Self-correct (macro undefined): same force, err=0, and 0101 shifts to 1011 with en=1, up=1.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared helpers for the Johnson sequencer: code <-> index conversion and legality test.
// Functions work on a JC_MAX_W-bit container; callers pass the live ring width.
package johnson_pkg;

    localparam int unsigned JC_MAX_W = 32'd64;

    function automatic int unsigned jc_idx_w(input int unsigned width);
        return $clog2(32'd2 * width);
    endfunction

    // Indices 0..width are k low ones; width+k is k low zeros with the rest ones.
    function automatic logic [JC_MAX_W-1:0] jc_encode(input int unsigned idx, input int unsigned width);
        logic [JC_MAX_W-1:0] code;
        code = {JC_MAX_W{1'b0}};
        for (int unsigned b = 0; b < JC_MAX_W; b++) begin
            if (b >= width) begin
                code[b] = 1'b0;
            end else if (idx <= width) begin
                code[b] = (b < idx);
            end else begin
                code[b] = (b >= idx - width);
            end
        end
        return code;
    endfunction

    function automatic int unsigned jc_decode(input logic [JC_MAX_W-1:0] q, input int unsigned width);
        int unsigned ones;
        ones = 32'd0;
        for (int unsigned b = 0; b < JC_MAX_W; b++) begin
            if ((b < width) && q[b]) begin
                ones = ones + 32'd1;
            end else begin
                ones = ones;
            end
        end
        if (q[0] || (ones == 32'd0)) begin
            return ones;
        end else begin
            return (32'd2 * width) - ones;
        end
    endfunction

    // A legal code has at most one 0/1 boundary inside the ring.
    function automatic logic jc_legal(input logic [JC_MAX_W-1:0] q, input int unsigned width);
        int unsigned edges;
        edges = 32'd0;
        for (int unsigned b = 1; b < JC_MAX_W; b++) begin
            if ((b < width) && (q[b] != q[b-1])) begin
                edges = edges + 32'd1;
            end else begin
                edges = edges;
            end
        end
        return (edges <= 32'd1);
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson-code decoder: binary index, one-hot decode and legality flag.
// Illegal codes decode to index 0 with an all-zero one-hot vector.
module johnson_decode
    import johnson_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IDX_W = int'(jc_idx_w(WIDTH))
)(
    input  logic [WIDTH-1:0]   i_q,
    output logic [IDX_W-1:0]   o_idx,
    output logic [2*WIDTH-1:0] o_dec,
    output logic               o_legal
);

    logic [JC_MAX_W-1:0] w_q_ext;

    // Decode the current code, gating outputs on legality.
    always_comb begin
        w_q_ext = JC_MAX_W'(i_q);
        o_legal = jc_legal(w_q_ext, WIDTH);
        if (o_legal) begin
            o_idx = IDX_W'(jc_decode(w_q_ext, WIDTH));
            o_dec = {{(2*WIDTH-1){1'b0}}, 1'b1} << o_idx;
        end else begin
            o_idx = {IDX_W{1'b0}};
            o_dec = {(2*WIDTH){1'b0}};
        end
    end

endmodule

// File: rtl/johnson_seq_gen.sv
// Johnson (twisted-ring) sequencer with enable, direction, indexed load and terminal count.
// Optional JOHNSON_SELF_CORRECT_EN: flag illegal codes on o_err and force them back to zero.
module johnson_seq_gen
    import johnson_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int IDX_W = int'(jc_idx_w(WIDTH))
)(
    input  logic               i_clk,
    input  logic               i_res,
    input  logic               i_en,
    input  logic               i_up,
    input  logic               i_load,
    input  logic [IDX_W-1:0]   i_load_idx,
    output logic [WIDTH-1:0]   o_q,
    output logic [IDX_W-1:0]   o_idx,
    output logic [2*WIDTH-1:0] o_dec,
    output logic               o_tc,
    output logic               o_err
);

    localparam int unsigned      SEQ_LEN  = 32'(2 * WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 32'd1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_legal;
    logic             w_load_ok;

    johnson_decode #(.WIDTH(WIDTH)) u_decode (
        .i_q     (r_q),
        .o_idx   (o_idx),
        .o_dec   (o_dec),
        .o_legal (w_legal)
    );

    // Out-of-range load indices are dropped so the ring simply holds.
    always_comb begin
        w_load_ok = (32'(i_load_idx) < SEQ_LEN);
    end

    // Next-state selection: load beats correction beats stepping.
    always_comb begin
        w_q_nxt = r_q;
        if (i_load) begin
            if (w_load_ok) begin
                w_q_nxt = WIDTH'(jc_encode(32'(i_load_idx), WIDTH));
            end else begin
                w_q_nxt = r_q;
            end
        end
`ifdef JOHNSON_SELF_CORRECT_EN
        else if (!w_legal) begin
            w_q_nxt = {WIDTH{1'b0}};
        end
`endif
        else if (i_en) begin
            if (i_up) begin
                w_q_nxt = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
            end else begin
                w_q_nxt = {~r_q[0], r_q[WIDTH-1:1]};
            end
        end else begin
            w_q_nxt = r_q;
        end
    end

    // Ring register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            r_q <= {WIDTH{1'b0}};
        end else begin
            r_q <= w_q_nxt;
        end
    end

    assign o_q = r_q;

    // Terminal count flags the cycle whose edge wraps the sequence.
    always_comb begin
        o_tc = 1'b0;
        if (i_en && !i_load && !i_res) begin
            o_tc = (i_up && (o_idx == LAST_IDX)) || (!i_up && (o_idx == {IDX_W{1'b0}}));
        end else begin
            o_tc = 1'b0;
        end
    end

`ifdef JOHNSON_SELF_CORRECT_EN
    // Illegal-code flag.
    always_comb begin
        o_err = ~w_legal;
    end
`else
    logic w_unused_legal;

    // Without self-correction the flag is tied low.
    always_comb begin
        o_err          = 1'b0;
        w_unused_legal = w_legal;
    end
`endif

endmodule

// File: tb/tb_johnson_seq_gen.sv
// Self-checking bench for johnson_seq_gen (WIDTH=4 main instance, WIDTH=3 for out-of-range loads).
// Reference model tracks the sequence position as an integer and derives codes arithmetically.
module tb_johnson_seq_gen;

    localparam int W  = 4;
    localparam int N  = 2 * W;

    logic         clk = 1'b0;
    logic         res = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
    logic [2:0]   load_idx = 3'd0;
    logic [W-1:0] q;
    logic [2:0]   idx;
    logic [N-1:0] dec;
    logic         tc, err;

    logic         w3_res = 1'b1, w3_en = 1'b0, w3_up = 1'b1, w3_load = 1'b0;
    logic [2:0]   w3_load_idx = 3'd0;
    logic [2:0]   w3_q;
    logic [2:0]   w3_idx;
    logic [5:0]   w3_dec;
    logic         w3_tc, w3_err;

    int   n_cmp = 0;
    int   n_err = 0;
    int   pos = 0;
    int   pos_nxt = 0;
    logic exp_tc = 1'b0;

    johnson_seq_gen #(.WIDTH(W)) dut (
        .i_clk(clk), .i_res(res), .i_en(en), .i_up(up), .i_load(load), .i_load_idx(load_idx),
        .o_q(q), .o_idx(idx), .o_dec(dec), .o_tc(tc), .o_err(err)
    );

    johnson_seq_gen #(.WIDTH(3)) dut_w3 (
        .i_clk(clk), .i_res(w3_res), .i_en(w3_en), .i_up(w3_up), .i_load(w3_load),
        .i_load_idx(w3_load_idx), .o_q(w3_q), .o_idx(w3_idx), .o_dec(w3_dec), .o_tc(w3_tc),
        .o_err(w3_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] code_of(input int p);
        if (p <= W) return W'((1 << p) - 1);
        else        return W'(((1 << W) - 1) & ~((1 << (p - W)) - 1));
    endfunction

    function automatic logic [N-1:0] dec_of(input int p);
        logic [N-1:0] d;
        d = '0;
        d[p] = 1'b1;
        return d;
    endfunction

    // Advance model to the state latched at the previous edge, then drive the next inputs.
    task automatic apply(input logic a_res, input logic a_en, input logic a_up,
                         input logic a_load, input int a_lidx);
        @(negedge clk);
        pos = pos_nxt;
        res = a_res; en = a_en; up = a_up; load = a_load; load_idx = 3'(a_lidx);
        exp_tc = a_en && !a_load && !a_res && ((a_up && pos == N - 1) || (!a_up && pos == 0));
        if (a_res)       pos_nxt = 0;
        else if (a_load) pos_nxt = (a_lidx < N) ? a_lidx : pos;
        else if (a_en)   pos_nxt = a_up ? (pos + 1) % N : (pos + N - 1) % N;
        else             pos_nxt = pos;
        #1;
    endtask

    task automatic test_reset;
        apply(1'b1, 1'b0, 1'b1, 1'b0, 0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 0);
        n_cmp++; if (q !== 4'b0000) begin n_err++; $display("FAIL reset_q: got %b want 0000", q); end
        n_cmp++; if (idx !== 3'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", idx); end
        n_cmp++; if (dec !== 8'h01) begin n_err++; $display("FAIL reset_dec: got %h want 01", dec); end
        n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL reset_tc: got %b want 0", tc); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_forward;
        for (int i = 0; i < 9; i++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b0, 0);
            n_cmp++; if (q !== code_of(i % N)) begin n_err++; $display("FAIL fwd_q[%0d]: got %b want %b", i, q, code_of(i % N)); end
            n_cmp++; if (idx !== 3'(i % N)) begin n_err++; $display("FAIL fwd_idx[%0d]: got %0d want %0d", i, idx, i % N); end
            n_cmp++; if (tc !== (i == 7)) begin n_err++; $display("FAIL fwd_tc[%0d]: got %b want %b", i, tc, (i == 7)); end
        end
    endtask

    task automatic test_reverse;
        apply(1'b1, 1'b0, 1'b1, 1'b0, 0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 0);
        n_cmp++; if (q !== 4'b0000 || tc !== 1'b1) begin n_err++; $display("FAIL rev_start: got q=%b tc=%b want q=0000 tc=1", q, tc); end
        apply(1'b0, 1'b1, 1'b0, 1'b0, 0);
        n_cmp++; if (q !== 4'b1000 || tc !== 1'b0) begin n_err++; $display("FAIL rev_step1: got q=%b tc=%b want q=1000 tc=0", q, tc); end
        apply(1'b0, 1'b1, 1'b1, 1'b0, 0);
        n_cmp++; if (q !== 4'b1100) begin n_err++; $display("FAIL rev_step2: got %b want 1100", q); end
        apply(1'b0, 1'b0, 1'b1, 1'b0, 0);
        n_cmp++; if (q !== 4'b1000) begin n_err++; $display("FAIL rev_toggle: got %b want 1000", q); end
    endtask

    task automatic test_load;
        apply(1'b0, 1'b1, 1'b1, 1'b1, 5);
        n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL load_tc: got %b want 0", tc); end
        apply(1'b0, 1'b0, 1'b1, 1'b0, 0);
        n_cmp++; if (q !== 4'b1110 || dec !== 8'h20 || idx !== 3'd5) begin
            n_err++; $display("FAIL load5: got q=%b dec=%h idx=%0d want q=1110 dec=20 idx=5", q, dec, idx);
        end
    endtask

    task automatic test_hold;
        apply(1'b0, 1'b0, 1'b1, 1'b1, 2);
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 0);
            n_cmp++; if (q !== 4'b0011 || tc !== 1'b0) begin n_err++; $display("FAIL hold[%0d]: got q=%b tc=%b want q=0011 tc=0", i, q, tc); end
        end
    endtask

    task automatic test_reset_mid;
        apply(1'b0, 1'b0, 1'b1, 1'b1, 3);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 5);
        n_cmp++; if (q !== 4'b0111 || tc !== 1'b0) begin n_err++; $display("FAIL rstmid_pre: got q=%b tc=%b want q=0111 tc=0", q, tc); end
        apply(1'b0, 1'b0, 1'b1, 1'b0, 0);
        n_cmp++; if (q !== 4'b0000 || idx !== 3'd0 || dec !== 8'h01) begin
            n_err++; $display("FAIL rstmid: got q=%b idx=%0d dec=%h want q=0000 idx=0 dec=01", q, idx, dec);
        end
    endtask

    task automatic test_load_range;
        @(negedge clk); #1;
        w3_res = 1'b0; w3_load = 1'b1; w3_load_idx = 3'd2; w3_en = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (w3_q !== 3'b011 || w3_idx !== 3'd2 || w3_dec !== 6'b000100) begin
            n_err++; $display("FAIL w3_load2: got q=%b idx=%0d dec=%b want q=011 idx=2 dec=000100", w3_q, w3_idx, w3_dec);
        end
        w3_load_idx = 3'd7; w3_en = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (w3_q !== 3'b011) begin n_err++; $display("FAIL w3_load7: got %b want 011", w3_q); end
        w3_load_idx = 3'd6;
        @(negedge clk); #1;
        n_cmp++; if (w3_q !== 3'b011) begin n_err++; $display("FAIL w3_load6: got %b want 011", w3_q); end
        w3_load = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (w3_q !== 3'b111 || w3_idx !== 3'd3) begin n_err++; $display("FAIL w3_step: got q=%b idx=%0d want q=111 idx=3", w3_q, w3_idx); end
        w3_en = 1'b0;
    endtask

    task automatic test_illegal;
`ifdef JOHNSON_SELF_CORRECT_EN
        apply(1'b0, 1'b0, 1'b1, 1'b0, 0);
`else
        apply(1'b0, 1'b1, 1'b1, 1'b0, 0);
`endif
        force dut.r_q = 4'b0101;
        #1;
`ifdef JOHNSON_SELF_CORRECT_EN
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL illegal_err: got %b want 1", err); end
`else
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL illegal_err: got %b want 0", err); end
`endif
        n_cmp++; if (dec !== 8'h00 || idx !== 3'd0 || tc !== 1'b0) begin
            n_err++; $display("FAIL illegal_dec: got dec=%h idx=%0d tc=%b want dec=00 idx=0 tc=0", dec, idx, tc);
        end
        release dut.r_q;
        apply(1'b1, 1'b0, 1'b1, 1'b0, 0);
`ifdef JOHNSON_SELF_CORRECT_EN
        n_cmp++; if (q !== 4'b0000) begin n_err++; $display("FAIL illegal_next: got %b want 0000", q); end
`else
        n_cmp++; if (q !== 4'b1011) begin n_err++; $display("FAIL illegal_next: got %b want 1011", q); end
`endif
        apply(1'b0, 1'b0, 1'b1, 1'b0, 0);
        n_cmp++; if (q !== 4'b0000) begin n_err++; $display("FAIL illegal_recover: got %b want 0000", q); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            apply(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0), int'($urandom_range(0, 7)));
            n_cmp++; if (q !== code_of(pos)) begin n_err++; $display("FAIL rnd_q[%0d]: got %b want %b", i, q, code_of(pos)); end
            n_cmp++; if (idx !== 3'(pos)) begin n_err++; $display("FAIL rnd_idx[%0d]: got %0d want %0d", i, idx, pos); end
            n_cmp++; if (dec !== dec_of(pos)) begin n_err++; $display("FAIL rnd_dec[%0d]: got %h want %h", i, dec, dec_of(pos)); end
            n_cmp++; if (tc !== exp_tc) begin n_err++; $display("FAIL rnd_tc[%0d]: got %b want %b", i, tc, exp_tc); end
            n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rnd_err[%0d]: got %b want 0", i, err); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_load();
        test_hold();
        test_reset_mid();
        test_load_range();
        test_illegal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
